// File: rtl/outpkt_csum_fifo.sv
`default_nettype none
// ============================================================================
// Module  : outpkt_csum_fifo
// Brief   : Output-packet tail stage: FWFT word FIFO that appends a 32-bit
//           inverted checksum as two trailing words per packet.
// Revision: 1.0 - initial release
// ============================================================================
module outpkt_csum_fifo #(
    parameter int ADDR_MSB = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] din,
    input  logic        pkt_new,
    input  logic        pkt_end,
    input  logic        wr_en,
    output logic        full,
    output logic [15:0] dout,
    output logic        pkt_end_out,
    input  logic        rd_en,
    output logic        empty
);

    localparam int                  C_DEPTH   = 2 ** (ADDR_MSB + 1);
    localparam logic [ADDR_MSB:0]   C_PTR_ONE = {{ADDR_MSB{1'b0}}, 1'b1};
    localparam logic [ADDR_MSB+1:0] C_CNT_ONE = {{(ADDR_MSB+1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_CS0  = 2'd1,
        S_CS1  = 2'd2
    } state_t;

    state_t              state_q;
    logic [16:0]         mem_q [0:C_DEPTH-1];
    logic [ADDR_MSB:0]   wptr_q;
    logic [ADDR_MSB:0]   rptr_q;
    logic [ADDR_MSB+1:0] count_q;
    logic [ADDR_MSB+1:0] count_d;
    logic [31:0]         sum_q;
    logic [31:0]         sum_d;
    logic                par_q;
    logic                par_d;
    logic                rst_d_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        pop;
    logic        odd;
    logic [31:0] csum;
    logic        wr_fifo;
    logic [16:0] wr_word;

    // Occupancy never exceeds depth, so its MSB alone marks a full FIFO.
    assign fifo_full  = count_q[ADDR_MSB+1];
    assign fifo_empty = (count_q == '0);

    assign full   = RST | rst_d_q | (state_q != S_DATA) | fifo_full;
    assign empty  = RST | fifo_empty;
    assign accept = wr_en & ~full;
    assign pop    = rd_en & ~empty;
    assign csum   = ~sum_q;

    assign dout        = mem_q[rptr_q][15:0];
    assign pkt_end_out = mem_q[rptr_q][16];

    // pkt_new restarts the sum before the current word is folded in.
    assign odd   = ~pkt_new & par_q;
    assign sum_d = (pkt_new ? 32'h0 : sum_q) + (odd ? {din, 16'h0} : {16'h0, din});
    assign par_d = ~odd;

    always_comb begin
        wr_fifo = 1'b0;
        wr_word = 17'h0;
        case (state_q)
            S_DATA: begin
                wr_fifo = accept;
                wr_word = {1'b0, din};
            end
            S_CS0: begin
                wr_fifo = ~fifo_full;
                wr_word = {1'b0, csum[15:0]};
            end
            S_CS1: begin
                wr_fifo = ~fifo_full;
                wr_word = {1'b1, csum[31:16]};
            end
            default: begin
                wr_fifo = 1'b0;
                wr_word = 17'h0;
            end
        endcase
    end

    assign count_d = count_q + (wr_fifo ? C_CNT_ONE : '0) - (pop ? C_CNT_ONE : '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_DATA;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            sum_q   <= 32'h0;
            par_q   <= 1'b0;
            rst_d_q <= 1'b1;
        end else begin
            rst_d_q <= 1'b0;
            count_q <= count_d;
            if (wr_fifo) wptr_q <= wptr_q + C_PTR_ONE;
            if (pop)     rptr_q <= rptr_q + C_PTR_ONE;
            case (state_q)
                S_DATA: begin
                    if (accept) begin
                        sum_q <= sum_d;
                        par_q <= par_d;
                        if (pkt_end) state_q <= S_CS0;
                    end
                end
                S_CS0: begin
                    if (!fifo_full) state_q <= S_CS1;
                end
                S_CS1: begin
                    if (!fifo_full) begin
                        sum_q   <= 32'h0;
                        par_q   <= 1'b0;
                        state_q <= S_DATA;
                    end
                end
                default: state_q <= S_DATA;
            endcase
        end
    end

    // Storage is not reset; pointers and occupancy alone define contents.
    always_ff @(posedge CLK) begin
        if (wr_fifo) mem_q[wptr_q] <= wr_word;
    end

endmodule
`default_nettype wire

// File: tb/tb_outpkt_csum_fifo.sv
`default_nettype none
// Testbench for outpkt_csum_fifo: directed packets plus randomized traffic,
// scoreboarded against a packet-list checksum model.
module tb_outpkt_csum_fifo;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] din = 16'h0;
    logic        pkt_new = 1'b0;
    logic        pkt_end = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        full;
    logic [15:0] dout;
    logic        pkt_end_out;
    logic        empty;

    always #5 CLK = ~CLK;

    outpkt_csum_fifo #(.ADDR_MSB(4)) dut (
        .CLK(CLK), .RST(RST), .din(din), .pkt_new(pkt_new), .pkt_end(pkt_end),
        .wr_en(wr_en), .full(full), .dout(dout), .pkt_end_out(pkt_end_out),
        .rd_en(rd_en), .empty(empty)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    logic [16:0] ref_log[$];
    logic [15:0] pkt_q[$];
    logic        s_full, s_empty, s_acc;
    logic [16:0] m_exp;
    int          nfull;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: the checksum is the inverted mod-2^32 sum of the packet's
    // words, odd-indexed words weighted by 2^16.
    task automatic model_word(input logic [15:0] w, input logic nw, input logic en);
        logic [31:0] s;
        logic [31:0] c;
        if (nw) pkt_q.delete();
        pkt_q.push_back(w);
        exp_q.push_back({1'b0, w});
        if (en) begin
            s = 32'h0;
            foreach (pkt_q[i]) s = s + ((i % 2 == 1) ? {pkt_q[i], 16'h0} : {16'h0, pkt_q[i]});
            c = ~s;
            exp_q.push_back({1'b0, c[15:0]});
            exp_q.push_back({1'b1, c[31:16]});
            pkt_q.delete();
        end
    endtask

    task automatic step(input logic wr, input logic [15:0] d, input logic nw,
                        input logic en, input logic rd);
        wr_en = wr; din = d; pkt_new = nw; pkt_end = en; rd_en = rd;
        @(negedge CLK);
        s_full  = full;
        s_empty = empty;
        s_acc   = wr & ~full;
        if (RST) begin
            exp_q.delete();
            pkt_q.delete();
        end else if (s_acc) begin
            model_word(d, nw, en);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic nw, input logic en,
                        input logic rd, output int nf);
        nf = 0;
        for (int k = 0; k < 100; k++) begin
            step(1'b1, d, nw, en, rd);
            if (s_acc) return;
            nf++;
        end
        chk("send_timeout", 32'(nf), 32'd0);
    endtask

    task automatic idle(input int n, input logic rd);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0, 1'b0, 1'b0, rd);
    endtask

    task automatic drain(input string nm, input int budget);
        for (int k = 0; k < budget; k++) begin
            step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
            if (exp_q.size() == 0 && s_empty) break;
        end
        chk({nm, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_count"}, 32'(got_q.size()), 32'(ref_log.size()));
        foreach (ref_log[i])
            chk($sformatf("%s[%0d]", nm, i), (i < got_q.size()) ? {15'h0, got_q[i]} : 32'hx,
                {15'h0, ref_log[i]});
    endtask

    // Monitor: every popped head word is logged and matched against the model.
    always @(negedge CLK) begin
        if (rd_en && !empty) begin
            got_q.push_back({pkt_end_out, dout});
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard: got %h expected none", {pkt_end_out, dout});
            end else begin
                m_exp = exp_q.pop_front();
                if ({pkt_end_out, dout} !== m_exp) begin
                    n_bad++;
                    $display("FAIL scoreboard: got %h expected %h", {pkt_end_out, dout}, m_exp);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge CLK); #1;
        RST = 1'b1;
        idle(2, 1'b0);
        chk("rst_full", 32'(s_full), 32'd1);
        chk("rst_empty", 32'(s_empty), 32'd1);
        RST = 1'b0;
        idle(1, 1'b0);
        chk("rst_d_full", 32'(s_full), 32'd1);
        chk("rst_d_empty", 32'(s_empty), 32'd1);
        idle(1, 1'b0);
        chk("post_rst_full", 32'(s_full), 32'd0);

        // Basic packet, FWFT visibility
        got_q.delete();
        send(16'h0001, 1'b1, 1'b0, 1'b1, nfull);
        chk("t1_empty_before", 32'(s_empty), 32'd1);
        send(16'h0002, 1'b0, 1'b0, 1'b1, nfull);
        chk("t1_empty_after", 32'(s_empty), 32'd0);
        send(16'h0003, 1'b0, 1'b1, 1'b1, nfull);
        drain("t1", 20);
        ref_log = {17'h00001, 17'h00002, 17'h00003, 17'h0FFFB, 17'h1FFFD};
        check_log("t1");

        // Modulo wrap of the accumulator
        got_q.delete();
        for (int i = 0; i < 4; i++) send(16'hFFFF, i == 0, i == 3, 1'b1, nfull);
        drain("t2", 20);
        ref_log = {17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h00001, 17'h10000};
        check_log("t2");

        // Back-to-back packets, full lasts exactly two cycles
        got_q.delete();
        send(16'h1234, 1'b1, 1'b1, 1'b1, nfull);
        send(16'hAAAA, 1'b0, 1'b0, 1'b1, nfull);
        chk("t3_full_cycles_a", 32'(nfull), 32'd2);
        send(16'h5555, 1'b0, 1'b1, 1'b1, nfull);
        nfull = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1, 1'b1);
            if (!s_full) break;
            nfull++;
        end
        chk("t3_full_cycles_b", 32'(nfull), 32'd2);
        drain("t3", 20);
        ref_log = {17'h01234, 17'h0EDCB, 17'h1FFFF, 17'h0AAAA, 17'h05555, 17'h05555, 17'h1AAAA};
        check_log("t3");

        // Backpressure: fill all 32 entries, checksum stalls until reads
        got_q.delete();
        for (int i = 0; i < 32; i++) send(16'(i + 1), i == 0, i == 31, 1'b0, nfull);
        idle(3, 1'b0);
        chk("t4_full", 32'(s_full), 32'd1);
        chk("t4_not_empty", 32'(s_empty), 32'd0);
        drain("t4", 60);
        ref_log.delete();
        for (int i = 0; i < 32; i++) ref_log.push_back(17'(i + 1));
        ref_log.push_back(17'h0FEFF);
        ref_log.push_back(17'h1FEEF);
        check_log("t4");

        // pkt_new mid-packet restarts the checksum
        got_q.delete();
        send(16'h0010, 1'b1, 1'b0, 1'b1, nfull);
        send(16'h0020, 1'b0, 1'b0, 1'b1, nfull);
        send(16'h0001, 1'b1, 1'b1, 1'b1, nfull);
        drain("t5", 20);
        ref_log = {17'h00010, 17'h00020, 17'h00001, 17'h0FFFE, 17'h1FFFF};
        check_log("t5");

        // Reset mid-packet discards buffered words
        got_q.delete();
        send(16'h0001, 1'b1, 1'b0, 1'b0, nfull);
        send(16'h0002, 1'b0, 1'b0, 1'b0, nfull);
        RST = 1'b1;
        idle(1, 1'b0);
        chk("t6_rst_full", 32'(s_full), 32'd1);
        chk("t6_rst_empty", 32'(s_empty), 32'd1);
        RST = 1'b0;
        idle(1, 1'b0);
        chk("t6_rst_d_full", 32'(s_full), 32'd1);
        chk("t6_rst_d_empty", 32'(s_empty), 32'd1);
        idle(1, 1'b0);
        chk("t6_full_clear", 32'(s_full), 32'd0);
        send(16'h0001, 1'b1, 1'b1, 1'b1, nfull);
        drain("t6", 20);
        ref_log = {17'h00001, 17'h0FFFE, 17'h1FFFF};
        check_log("t6");

        // Randomized traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            RST = ($urandom_range(0, 249) == 0);
            step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) < 3, $urandom_range(0, 9) < 6);
        end
        RST = 1'b0;
        drain("rand", 300);
        chk("rand_final_empty", 32'(s_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
